// File: rtl/matmul_result_streamer_if.sv
// Bundle between the matmul engine result port, the streamer and the Q1.15 consumer.
// Carries the flattened result matrix plus the per-element output stream.
// master = streamer side, slave = engine/consumer side.
interface matmul_result_streamer_if #(
  parameter int M = 16,
  parameter int N = 16
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic signed [31:0] c_in [M*N];
  logic               c_valid;
  logic               c_ready;
  logic [15:0]        m_data;
  logic               m_valid;
  logic               m_ready;
  logic [RW-1:0]      m_row;
  logic [CW-1:0]      m_col;
  logic               m_last;
  logic               m_sat;
  logic               overrun;

  modport master (
    input  c_in, c_valid, m_ready,
    output c_ready, m_data, m_valid, m_row, m_col, m_last, m_sat, overrun
  );

  modport slave (
    output c_in, c_valid, m_ready,
    input  c_ready, m_data, m_valid, m_row, m_col, m_last, m_sat, overrun
  );
endinterface

// File: rtl/matmul_result_streamer.sv
// Captures a Q2.30 M x N result matrix and streams it row-major as saturated Q1.15 beats.
// Latency: element 0 valid two edges after the c_valid edge, then one beat per cycle.
// Backpressure: m_ready low freezes the beat; c_valid outside IDLE is dropped and flagged.
module matmul_result_streamer #(
  parameter int M          = 16,
  parameter int N          = 16,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  matmul_result_streamer_if.master io
);
  localparam int MN = M * N;
  localparam int IW = $clog2(MN);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]     LAST_IDX = IW'(MN - 1);
  localparam logic signed [32:0] ROUND   = 33'sd1 <<< (FRAC_SHIFT - 1);
  localparam logic signed [32:0] POS_MAX = 33'sd32767;
  localparam logic signed [32:0] NEG_MIN = -33'sd32768;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      idx, idx_nxt, load_idx;
  logic               load_en, vld_nxt;
  logic signed [31:0] mem [MN];

  // Round half up, arithmetic shift, then clamp to Q1.15; returns {sat, data}.
  function automatic logic [16:0] requant(input logic signed [31:0] c);
    logic signed [32:0] t;
    t = (33'(c) + ROUND) >>> FRAC_SHIFT;
    if (t > POS_MAX)      requant = {1'b1, 16'h7FFF};
    else if (t < NEG_MIN) requant = {1'b1, 16'h8000};
    else                  requant = {1'b0, t[15:0]};
  endfunction

  assign io.c_ready = (state == IDLE);

  // State and element pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state: the first STREAM cycle only loads the output stage, later cycles advance on transfer.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_en   = 1'b0;
    load_idx  = idx;
    vld_nxt   = io.m_valid;
    case (state)
      IDLE: begin
        vld_nxt = 1'b0;
        if (io.c_valid) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (!io.m_valid) begin
          load_en = 1'b1;
          vld_nxt = 1'b1;
        end else if (io.m_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            vld_nxt   = 1'b0;
          end else begin
            idx_nxt  = idx + 1'b1;
            load_idx = idx + 1'b1;
            load_en  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Matrix buffer is written only when a new matrix is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && io.c_valid) mem <= io.c_in;
  end

  // Registered output beat; fields only change when a new element is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      io.m_valid <= 1'b0;
      io.m_data  <= '0;
      io.m_row   <= '0;
      io.m_col   <= '0;
      io.m_last  <= 1'b0;
      io.m_sat   <= 1'b0;
    end else begin
      io.m_valid <= vld_nxt;
      if (load_en) begin
        {io.m_sat, io.m_data} <= requant(mem[load_idx]);
        io.m_row  <= RW'(load_idx / N);
        io.m_col  <= CW'(load_idx % N);
        io.m_last <= (load_idx == LAST_IDX);
      end
    end
  end

  // Sticky flag for matrices offered while the previous one is still streaming.
  always_ff @(posedge clk) begin
    if (rst)                                io.overrun <= 1'b0;
    else if (io.c_valid && state != IDLE)   io.overrun <= 1'b1;
  end
endmodule
